// File: rtl/lcd_port_pkg.sv
// Shared constants for the LCD port multiplexer: control-pin bit positions,
// default idle levels and guard FSM encoding.
package lcd_port_pkg;

  // Control bus layout: {rst, bl, de_cs, vs_rs, hs_wr, clk_rd}
  localparam int unsigned CTRL_RST    = 5;
  localparam int unsigned CTRL_BL     = 4;
  localparam int unsigned CTRL_DE_CS  = 3;
  localparam int unsigned CTRL_VS_RS  = 2;
  localparam int unsigned CTRL_HS_WR  = 1;
  localparam int unsigned CTRL_CLK_RD = 0;

  // Safe levels held on the control pins while ownership changes hands
  localparam logic [5:0] IDLE_CTRL_DEFAULT = 6'b101111;

  // Guard FSM encoding
  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_GUARD = 1'b1;

  // Reset pin image: idle levels with the panel held in reset
  function automatic logic [5:0] reset_ctrl(input logic [5:0] idle);
    logic [5:0] r;
    r           = idle;
    r[CTRL_RST] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/lcd_id_decode.sv
// Maps the panel ID to the source index that should own the LCD port.
module lcd_id_decode #(
  parameter logic [31:0] RGB_IDS = 32'h43708010,
  parameter int unsigned RGB_SRC = 1,
  parameter int unsigned MCU_SRC = 2,
  parameter int unsigned SRC_W   = 2
) (
  input  logic             lcd_init_done,
  input  logic [15:0]      lcd_id,
  output logic [SRC_W-1:0] target
);

  logic rgb_hit;
  logic unused_id_lo;

  // Only the upper ID byte identifies the panel family
  assign unused_id_lo = ^lcd_id[7:0];

  // Initialiser owns the port until init completes, then RGB vs MCU by ID
  always_comb begin
    rgb_hit = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (lcd_id[15:8] == RGB_IDS[8*i +: 8]) rgb_hit = 1'b1;
    end
    if (!lcd_init_done) target = '0;
    else if (rgb_hit)   target = SRC_W'(RGB_SRC);
    else                target = SRC_W'(MCU_SRC);
  end

endmodule

// File: rtl/lcd_port_mux.sv
// Shares one physical LCD port between NUM_SRC driver engines, inserting a
// guard interval of idle pin levels whenever ownership changes.
module lcd_port_mux
  import lcd_port_pkg::*;
#(
  parameter int unsigned NUM_SRC      = 3,
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter logic [5:0]  IDLE_CTRL    = IDLE_CTRL_DEFAULT,
  parameter logic [31:0] RGB_IDS      = 32'h43708010,
  parameter int unsigned RGB_SRC      = 1,
  parameter int unsigned MCU_SRC      = 2,
  localparam int unsigned SRC_W       = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      lcd_init_done,
  input  logic [15:0]               lcd_id,
  input  logic [6*NUM_SRC-1:0]      src_ctrl,
  input  logic [DATA_W*NUM_SRC-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_oe,
  input  logic [NUM_SRC-1:0]        src_pixel_en,
  input  logic [DATA_W-1:0]         pixel_data,
  output logic                      pixel_en,
  output logic [DATA_W*NUM_SRC-1:0] src_pixel_data,
  output logic [DATA_W-1:0]         lcd_data_in,
  output logic                      lcd_rst,
  output logic                      lcd_bl,
  output logic                      lcd_de_cs,
  output logic                      lcd_vs_rs,
  output logic                      lcd_hs_wr,
  output logic                      lcd_clk_rd,
  inout  wire  [DATA_W-1:0]         lcd_data,
  output logic [SRC_W-1:0]          active_src,
  output logic                      switching
);

  localparam int unsigned     CNT_W      = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(GUARD_CYCLES - 1);

  logic [0:0]        state_q, state_d;
  logic [SRC_W-1:0]  active_q, active_d;
  logic [SRC_W-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SRC_W-1:0]  target;
  logic [5:0]        ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic              oe_q;
  logic [DATA_W-1:0] data_in_q;

  lcd_id_decode #(
    .RGB_IDS (RGB_IDS),
    .RGB_SRC (RGB_SRC),
    .MCU_SRC (MCU_SRC),
    .SRC_W   (SRC_W)
  ) u_id_decode (
    .lcd_init_done (lcd_init_done),
    .lcd_id        (lcd_id),
    .target        (target)
  );

  // Guard FSM next-state: a new target (re)starts the guard; a target back to
  // the current owner still runs the guard to completion.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    if (state_q == ST_RUN) begin
      if (target != active_q) begin
        state_d   = ST_GUARD;
        pending_d = target;
        cnt_d     = GUARD_LOAD;
      end
    end else begin
      if (target != pending_q) begin
        pending_d = target;
        cnt_d     = GUARD_LOAD;
      end else if (cnt_q == '0) begin
        active_d = pending_q;
        state_d  = ST_RUN;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  // FSM registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      active_q  <= '0;
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Pin registers follow the next-cycle owner so the new source reaches the
  // pins in the same cycle active_src updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= reset_ctrl(IDLE_CTRL);
      oe_q   <= 1'b0;
      data_q <= '0;
    end else if (state_d == ST_GUARD) begin
      ctrl_q <= IDLE_CTRL;
      oe_q   <= 1'b0;
      data_q <= src_data[DATA_W*active_d +: DATA_W];
    end else begin
      ctrl_q <= src_ctrl[6*active_d +: 6];
      oe_q   <= src_oe[active_d];
      data_q <= src_data[DATA_W*active_d +: DATA_W];
    end
  end

  // Pin readback register
  always_ff @(posedge clk) begin
    if (rst) data_in_q <= '0;
    else     data_in_q <= lcd_data;
  end

  // Pixel routing to/from the current owner
  always_comb begin
    src_pixel_data = '0;
    src_pixel_data[DATA_W*active_q +: DATA_W] = pixel_data;
    pixel_en = (state_q == ST_RUN) ? src_pixel_en[active_q] : 1'b0;
  end

  assign lcd_data    = oe_q ? data_q : {DATA_W{1'bz}};
  assign lcd_data_in = data_in_q;
  assign lcd_rst     = ctrl_q[CTRL_RST];
  assign lcd_bl      = ctrl_q[CTRL_BL];
  assign lcd_de_cs   = ctrl_q[CTRL_DE_CS];
  assign lcd_vs_rs   = ctrl_q[CTRL_VS_RS];
  assign lcd_hs_wr   = ctrl_q[CTRL_HS_WR];
  assign lcd_clk_rd  = ctrl_q[CTRL_CLK_RD];
  assign active_src  = active_q;
  assign switching   = (state_q == ST_GUARD);

endmodule

// File: tb/tb_lcd_port_mux.sv
// Self-checking bench for lcd_port_mux: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_lcd_port_mux;

  localparam int NS = 3;
  localparam int DW = 16;
  localparam int G  = 4;
  localparam logic [5:0] IDLE     = 6'b101111;
  localparam logic [5:0] RST_PINS = 6'b001111;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lcd_init_done = 1'b0;
  logic [15:0]       lcd_id = '0;
  logic [6*NS-1:0]   src_ctrl = '0;
  logic [DW*NS-1:0]  src_data = '0;
  logic [NS-1:0]     src_oe = '0;
  logic [NS-1:0]     src_pixel_en = '0;
  logic [DW-1:0]     pixel_data = '0;
  logic              pixel_en;
  logic [DW*NS-1:0]  src_pixel_data;
  logic [DW-1:0]     lcd_data_in;
  logic              lcd_rst, lcd_bl, lcd_de_cs, lcd_vs_rs, lcd_hs_wr, lcd_clk_rd;
  wire  [DW-1:0]     lcd_data;
  logic [1:0]        active_src;
  logic              switching;
  logic [5:0]        pins;

  logic              tb_oe = 1'b0;
  logic [DW-1:0]     tb_drv = '0;
  assign lcd_data = tb_oe ? tb_drv : 'z;
  assign pins = {lcd_rst, lcd_bl, lcd_de_cs, lcd_vs_rs, lcd_hs_wr, lcd_clk_rd};

  always #5 clk = ~clk;

  lcd_port_mux #(
    .NUM_SRC      (NS),
    .DATA_W       (DW),
    .GUARD_CYCLES (G),
    .IDLE_CTRL    (IDLE),
    .RGB_IDS      (32'h43708010),
    .RGB_SRC      (1),
    .MCU_SRC      (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .lcd_init_done  (lcd_init_done),
    .lcd_id         (lcd_id),
    .src_ctrl       (src_ctrl),
    .src_data       (src_data),
    .src_oe         (src_oe),
    .src_pixel_en   (src_pixel_en),
    .pixel_data     (pixel_data),
    .pixel_en       (pixel_en),
    .src_pixel_data (src_pixel_data),
    .lcd_data_in    (lcd_data_in),
    .lcd_rst        (lcd_rst),
    .lcd_bl         (lcd_bl),
    .lcd_de_cs      (lcd_de_cs),
    .lcd_vs_rs      (lcd_vs_rs),
    .lcd_hs_wr      (lcd_hs_wr),
    .lcd_clk_rd     (lcd_clk_rd),
    .lcd_data       (lcd_data),
    .active_src     (active_src),
    .switching      (switching)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: owner, pending owner, guard cycles still to run
  logic [7:0]    rgb_bytes [4] = '{8'h43, 8'h70, 8'h80, 8'h10};
  int            m_active  = 0;
  int            m_pending = 0;
  bit            m_guard   = 1'b0;
  int            m_left    = 0;
  logic [5:0]    m_ctrl    = '0;
  bit            m_oe      = 1'b0;
  logic [DW-1:0] m_data    = '0;
  logic [DW-1:0] m_rd      = '0;
  bit            m_rd_known = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int wanted_owner(input logic init, input logic [15:0] id);
    if (!init) return 0;
    foreach (rgb_bytes[i]) if (id[15:8] == rgb_bytes[i]) return 1;
    return 2;
  endfunction

  // Advance the model across one rising edge using the inputs of the cycle just ended
  task automatic model_edge();
    int tgt;
    bit bus_known;
    logic [DW-1:0] bus;
    bus_known = (m_oe != tb_oe);
    bus = m_oe ? m_data : tb_drv;
    if (rst) begin
      m_active = 0; m_pending = 0; m_guard = 1'b0; m_left = 0;
      m_ctrl = RST_PINS; m_oe = 1'b0; m_data = '0;
      m_rd = '0; m_rd_known = 1'b1;
    end else begin
      m_rd = bus;
      m_rd_known = bus_known;
      tgt = wanted_owner(lcd_init_done, lcd_id);
      if (!m_guard) begin
        if (tgt != m_active) begin
          m_guard = 1'b1; m_pending = tgt; m_left = G;
        end
      end else if (tgt != m_pending) begin
        m_pending = tgt; m_left = G;
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_guard = 1'b0; m_active = m_pending;
        end
      end
      if (m_guard) begin
        m_ctrl = IDLE; m_oe = 1'b0;
      end else begin
        m_ctrl = src_ctrl[6*m_active +: 6];
        m_oe   = src_oe[m_active];
        m_data = src_data[DW*m_active +: DW];
      end
    end
  endtask

  task automatic check_outputs();
    logic [DW*NS-1:0] exp_pix;
    exp_pix = '0;
    exp_pix[DW*m_active +: DW] = pixel_data;
    check("ctrl_pins", pins, m_ctrl);
    check("active_src", active_src, m_active);
    check("switching", switching, m_guard);
    check("pixel_en", pixel_en, m_guard ? 1'b0 : src_pixel_en[m_active]);
    check("src_pixel_data", src_pixel_data, exp_pix);
    if (m_oe) check("lcd_data_out", lcd_data, m_data);
    if (m_rd_known) check("lcd_data_in", lcd_data_in, m_rd);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Count consecutive guard cycles (bounded); optionally drive the bus mid-guard
  task automatic guard_run(input bit drive_bus, output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (!switching) break;
      n++;
      check("guard_pins", pins, IDLE);
      if (drive_bus && n == 1) tb_oe = 1'b1;
      if (drive_bus && n == 2) check("guard_bus_released", lcd_data, tb_drv);
      if (drive_bus && n == 3) tb_oe = 1'b0;
    end
  endtask

  initial begin
    int n;
    logic [63:0] r;

    // Reset with the initialiser driving its own pin pattern
    src_ctrl = {6'b010101, 6'b110011, 6'b111010};
    src_data = {16'h1234, 16'hA5A5, 16'h0F0F};
    src_oe   = 3'b110;
    rst = 1'b1;
    repeat (3) cycle();
    check("reset_pins", pins, 6'b001111);
    check("reset_active", active_src, 0);
    check("reset_switching", switching, 0);
    check("reset_readback", lcd_data_in, 0);
    rst = 1'b0;
    cycle();
    check("post_reset_pins", pins, 6'b111010);
    check("post_reset_active", active_src, 0);

    // RGB panel after init: 4-cycle guard, bus released during it
    tb_drv = 16'h5A5A;
    lcd_init_done = 1'b1;
    lcd_id = 16'h7016;
    guard_run(1'b1, n);
    tb_oe = 1'b0;
    check("guard_len_rgb", n, G);
    check("active_rgb", active_src, 1);
    check("pins_rgb", pins, 6'b110011);
    src_pixel_en = 3'b010;
    #1 check("pixel_en_follow_hi", pixel_en, 1);
    src_pixel_en = 3'b101;
    #1 check("pixel_en_follow_lo", pixel_en, 0);

    // MCU panel: pixel data routed only to slice 2
    lcd_id = 16'h9341;
    guard_run(1'b0, n);
    check("guard_len_mcu", n, G);
    check("active_mcu", active_src, 2);
    pixel_data = 16'hF800;
    #1 check("pixel_slices", src_pixel_data, {16'hF800, 32'h0});

    // Back to the initialiser, then retarget 1 -> 2 inside the guard
    lcd_init_done = 1'b0;
    guard_run(1'b0, n);
    check("active_back_init", active_src, 0);
    lcd_init_done = 1'b1;
    lcd_id = 16'h7016;
    cycle();
    check("restart_first_guard", switching, 1);
    lcd_id = 16'h9341;
    guard_run(1'b0, n);
    check("restart_total_idle", n + 1, 5);
    check("restart_final_src", active_src, 2);

    // Reset asserted on the third guard cycle
    lcd_id = 16'h7016;
    cycle(); cycle(); cycle();
    check("pre_reset_guard", switching, 1);
    rst = 1'b1;
    lcd_init_done = 1'b0;
    cycle();
    check("mid_guard_rst_pin", lcd_rst, 0);
    check("mid_guard_rst_active", active_src, 0);
    check("mid_guard_rst_switching", switching, 0);
    rst = 1'b0;
    cycle();

    // Pin readback while the initialiser releases the bus
    src_oe = 3'b000;
    cycle();
    tb_drv = 16'hA5A5;
    tb_oe = 1'b1;
    cycle();
    check("readback", lcd_data_in, 16'hA5A5);
    tb_oe = 1'b0;

    // Randomized traffic against the model
    lcd_init_done = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = {$urandom(), $urandom()};
      src_data = r[DW*NS-1:0];
      r = {$urandom(), $urandom()};
      src_ctrl = r[6*NS-1:0];
      src_oe = NS'($urandom());
      src_pixel_en = NS'($urandom());
      pixel_data = DW'($urandom());
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 39) == 0) lcd_init_done = ~lcd_init_done;
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 4))
          0: lcd_id = {8'h43, 8'($urandom())};
          1: lcd_id = {8'h70, 8'($urandom())};
          2: lcd_id = {8'h80, 8'($urandom())};
          3: lcd_id = {8'h10, 8'($urandom())};
          default: lcd_id = 16'($urandom());
        endcase
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule
